// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath stages (serializer and the
// downstream serial/parallel converters).
package serial_pkg;

    localparam logic STATE_IDLE_ENC  = 1'b0;
    localparam logic STATE_SHIFT_ENC = 1'b1;

    typedef enum logic {
        IDLE  = STATE_IDLE_ENC,
        SHIFT = STATE_SHIFT_ENC
    } serial_state_e;

endpackage : serial_pkg

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter: loads a WIDTH-bit word with a valid/ready
// handshake and emits it one bit per clock, supporting gapless back-to-back words.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             SDO,
    output logic             SDO_VALID,
    output logic             DONE
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    serial_state_e    state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;

    logic             shifting_s;
    logic             last_s;
    logic             ready_s;
    logic             load_s;
    logic             out_bit_s;
    logic [WIDTH-1:0] shifted_s;

    // Handshake decode; a word may be accepted while its predecessor's last bit is on the wire
    always_comb begin
        shifting_s = (state_r == SHIFT);
        last_s     = shifting_s && (cnt_r == CNT_LAST);
        ready_s    = (state_r == IDLE) || last_s;
        load_s     = LOAD_VALID && ready_s;
    end

    // Output-end bit selection and zero-filled shift toward that end
    always_comb begin
        if (MSB_FIRST) begin
            out_bit_s = shreg_r[WIDTH-1];
            shifted_s = {shreg_r[WIDTH-2:0], 1'b0};
        end else begin
            out_bit_s = shreg_r[0];
            shifted_s = {1'b0, shreg_r[WIDTH-1:1]};
        end
    end

    // FSM, bit counter and shift register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r <= SHIFT;
                        shreg_r <= DIN;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                        shreg_r <= shreg_r;
                        cnt_r   <= cnt_r;
                    end
                end
                SHIFT: begin
                    if (load_s) begin
                        state_r <= SHIFT;
                        shreg_r <= DIN;
                        cnt_r   <= '0;
                    end else if (last_s) begin
                        state_r <= IDLE;
                        shreg_r <= '0;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= SHIFT;
                        shreg_r <= shifted_s;
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shreg_r <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Outputs are plain decodes of the state registers, so reset clears them at once
    always_comb begin
        LOAD_READY = ready_s;
        SDO_VALID  = shifting_s;
        DONE       = last_s;
        if (shifting_s) begin
            SDO = out_bit_s;
        end else begin
            SDO = 1'b0;
        end
    end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: two instances (MSB-first and LSB-first)
// checked against a bit-queue scoreboard, plus a 3-bit downstream shift register.
module tb_piso_serializer;

    logic       CLK;
    logic       RST_N;
    logic [2:0] din_a, din_b;
    logic       lv_a, lv_b;
    logic       rdy_a, rdy_b;
    logic       sdo_a, sdo_b;
    logic       sv_a, sv_b;
    logic       done_a, done_b;
    logic [2:0] q_r;

    int total = 0;
    int bad   = 0;
    logic qa[$];
    logic qb[$];

    piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b1)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .DIN(din_a), .LOAD_VALID(lv_a),
        .LOAD_READY(rdy_a), .SDO(sdo_a), .SDO_VALID(sv_a), .DONE(done_a)
    );

    piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b0)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .DIN(din_b), .LOAD_VALID(lv_b),
        .LOAD_READY(rdy_b), .SDO(sdo_b), .SDO_VALID(sv_b), .DONE(done_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Downstream serial shift register fed by the MSB-first serializer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) q_r <= 3'b000;
        else if (sv_a) q_r <= {q_r[1:0], sdo_a};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_a(input logic [2:0] w);
        for (int i = 2; i >= 0; i--) qa.push_back(w[i]);
    endtask

    task automatic push_b(input logic [2:0] w);
        for (int i = 0; i <= 2; i++) qb.push_back(w[i]);
    endtask

    // Check one cycle of instance A; a valid cycle consumes one scoreboard bit
    task automatic chk_a(input string tag, input logic ev, input logic ed, input logic er);
        logic e;
        chk({tag, ".valid"}, {31'd0, sv_a}, {31'd0, ev});
        chk({tag, ".done"},  {31'd0, done_a}, {31'd0, ed});
        chk({tag, ".ready"}, {31'd0, rdy_a}, {31'd0, er});
        if (ev) begin
            if (qa.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk({tag, ".sdo"}, {31'd0, sdo_a}, {31'd0, e});
            end
        end else begin
            chk({tag, ".sdo_idle"}, {31'd0, sdo_a}, 32'd0);
        end
    endtask

    task automatic chk_b(input string tag, input logic ev, input logic ed);
        logic e;
        chk({tag, ".valid"}, {31'd0, sv_b}, {31'd0, ev});
        chk({tag, ".done"},  {31'd0, done_b}, {31'd0, ed});
        if (ev) begin
            if (qb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk({tag, ".sdo"}, {31'd0, sdo_b}, {31'd0, e});
            end
        end else begin
            chk({tag, ".sdo_idle"}, {31'd0, sdo_b}, 32'd0);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        din_a = 3'b000; din_b = 3'b000;
        lv_a  = 1'b0;   lv_b  = 1'b0;
        #1;
        chk_a("reset", 1'b0, 1'b0, 1'b1);
        cyc(); cyc();
        RST_N = 1'b1;
        cyc();
        chk_a("idle", 1'b0, 1'b0, 1'b1);

        // Single word 101, MSB first, then downstream register contents
        din_a = 3'b101; lv_a = 1'b1; push_a(3'b101);
        cyc(); lv_a = 1'b0;
        chk_a("w101.b0", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("w101.b1", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("w101.b2", 1'b1, 1'b1, 1'b1);
        cyc(); chk_a("w101.after", 1'b0, 1'b0, 1'b1);
        chk("chain.q", {29'd0, q_r}, 32'h5);

        // Back-to-back words with LOAD_VALID held; the early 011 request must wait
        din_a = 3'b100; lv_a = 1'b1; push_a(3'b100);
        cyc(); din_a = 3'b011;
        chk_a("b2b.1", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("b2b.2", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("b2b.3", 1'b1, 1'b1, 1'b1);
        push_a(3'b011);
        cyc(); lv_a = 1'b0;
        chk_a("b2b.4", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("b2b.5", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("b2b.6", 1'b1, 1'b1, 1'b1);
        cyc(); chk_a("b2b.after", 1'b0, 1'b0, 1'b1);

        // Load pulse while busy is ignored
        din_a = 3'b000; lv_a = 1'b1; push_a(3'b000);
        cyc(); lv_a = 1'b0;
        chk_a("ign.b0", 1'b1, 1'b0, 1'b0);
        cyc(); din_a = 3'b111; lv_a = 1'b1;
        chk_a("ign.b1", 1'b1, 1'b0, 1'b0);
        cyc(); lv_a = 1'b0;
        chk_a("ign.b2", 1'b1, 1'b1, 1'b1);
        cyc(); chk_a("ign.after", 1'b0, 1'b0, 1'b1);
        cyc(); chk_a("ign.after2", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset after the first bit drops the word at once
        din_a = 3'b101; lv_a = 1'b1; push_a(3'b101);
        cyc(); lv_a = 1'b0;
        chk_a("rst.b0", 1'b1, 1'b0, 1'b0);
        #2; RST_N = 1'b0;
        #1;
        qa.delete();
        chk_a("rst.async", 1'b0, 1'b0, 1'b1);
        cyc(); chk_a("rst.held", 1'b0, 1'b0, 1'b1);
        RST_N = 1'b1;
        cyc(); chk_a("rst.released", 1'b0, 1'b0, 1'b1);
        din_a = 3'b101; lv_a = 1'b1; push_a(3'b101);
        cyc(); lv_a = 1'b0;
        chk_a("rst.w.b0", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("rst.w.b1", 1'b1, 1'b0, 1'b0);
        cyc(); chk_a("rst.w.b2", 1'b1, 1'b1, 1'b1);
        cyc(); chk_a("rst.w.after", 1'b0, 1'b0, 1'b1);
        chk("rst.chain.q", {29'd0, q_r}, 32'h5);

        // LSB-first instance: 110 goes out as 0,1,1
        chk_b("lsb.idle", 1'b0, 1'b0);
        din_b = 3'b110; lv_b = 1'b1; push_b(3'b110);
        cyc(); lv_b = 1'b0;
        chk_b("lsb.b0", 1'b1, 1'b0);
        cyc(); chk_b("lsb.b1", 1'b1, 1'b0);
        cyc(); chk_b("lsb.b2", 1'b1, 1'b1);
        cyc(); chk_b("lsb.after", 1'b0, 1'b0);
        chk("lsb.ready", {31'd0, rdy_b}, 32'd1);
        chk("sb.drained", qa.size() + qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_piso_serializer
